// File: rtl/line_clear.sv
// Row-compaction engine for the 10x20 playfield: drops surviving rows over
// full rows bottom-up, zero-fills the vacated top rows, reports the count.
module line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       board_rdata,
    output logic [3:0] board_rx,
    output logic [4:0] board_ry,
    output logic       board_we,
    output logic [3:0] board_wx,
    output logic [4:0] board_wy,
    output logic       board_wdata,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DECIDE,
        COPY,
        CLEAR,
        FINISH
    } state_t;

    localparam logic [3:0] XLAST = 4'(COLS - 1);
    localparam logic [4:0] YLAST = 5'(ROWS - 1);

    state_t          state;
    logic [4:0]      src;
    logic [4:0]      dst;
    logic [3:0]      x;
    logic [COLS-1:0] rowbuf;
    logic [4:0]      lines;

    logic       row_full;
    logic       full_hit;
    logic       advance;
    logic [4:0] lines_n;

    assign row_full = &rowbuf;
    assign full_hit = (state == DECIDE) && row_full;
    assign lines_n  = lines + 5'(full_hit);

    // A row is finished when DECIDE needs no copy, or on the last COPY beat.
    assign advance = ((state == DECIDE) && (row_full || (dst == src)))
                   || ((state == COPY) && (x == XLAST));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            x             <= '0;
            rowbuf        <= '0;
            lines         <= '0;
            lines_cleared <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src           <= YLAST;
                        dst           <= YLAST;
                        lines         <= '0;
                        x             <= '0;
                        lines_cleared <= '0;
                        state         <= READ;
                    end
                end
                READ: begin
                    if (x != 4'd0) rowbuf[x - 4'd1] <= board_rdata;
                    if (x == XLAST) begin
                        x     <= '0;
                        state <= WAIT;
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                WAIT: begin
                    rowbuf[XLAST] <= board_rdata;
                    state         <= DECIDE;
                end
                DECIDE: begin
                    if (row_full) lines <= lines_n;
                    else if (dst != src) state <= COPY;
                    else dst <= dst - 5'd1;
                end
                COPY: begin
                    if (x == XLAST) begin
                        x   <= '0;
                        dst <= dst - 5'd1;
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                CLEAR: begin
                    // dst is reused as the row counter for the zero fill
                    if (x == XLAST) begin
                        x   <= '0;
                        dst <= dst + 5'd1;
                        if (dst == lines - 5'd1) begin
                            lines_cleared <= lines;
                            state         <= FINISH;
                        end
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (advance) begin
                x <= '0;
                if (src != 5'd0) begin
                    src   <= src - 5'd1;
                    state <= READ;
                end else if (lines_n != 5'd0) begin
                    dst   <= '0;
                    state <= CLEAR;
                end else begin
                    state <= FINISH;
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign board_rx    = (state == READ) ? x : 4'd0;
    assign board_ry    = (state == READ) ? src : 5'd0;
    assign board_we    = (state == COPY) || (state == CLEAR);
    assign board_wx    = board_we ? x : 4'd0;
    assign board_wy    = board_we ? dst : 5'd0;
    assign board_wdata = (state == COPY) ? rowbuf[x] : 1'b0;

endmodule
